// File: rtl/mem_layout_pkg.sv
// rtl/mem_layout_pkg.sv - shared widths and state encoding for the DAC burst scheduler
package mem_layout_pkg;

  localparam int DEF_BURST_W = 16;
  localparam int DEF_GAP_W   = 16;
  localparam int DEF_REP_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - inter-burst idle down-counter; expired marks the last idle cycle
module gap_timer
  import mem_layout_pkg::*;
#(
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             enable,
  input  logic [GAP_W-1:0] gap,
  output logic             expired
);

  logic [GAP_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= gap;
    end else if (enable && (count != '0)) begin
      count <= count - GAP_W'(1);
    end
  end

  // Loaded with gap on entry, so a value of 1 means this is the final idle cycle.
  assign expired = (count <= GAP_W'(1));

endmodule

// File: rtl/dac_burst_scheduler.sv
// rtl/dac_burst_scheduler.sv - gates DAC batches into bursts separated by idle gaps
module dac_burst_scheduler
  import mem_layout_pkg::*;
#(
  parameter int BURST_W = DEF_BURST_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int REP_W   = DEF_REP_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_valid,
  output logic               cfg_rdy,
  input  logic [BURST_W-1:0] cfg_burst_size,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic [REP_W-1:0]   cfg_repeats,
  input  logic               start,
  input  logic               stop,
  input  logic               dac_rdy,
  input  logic               src_valid,
  output logic               gate,
  output logic               halt,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] batch_count,
  output logic [REP_W-1:0]   burst_count
);

  sched_state_t       state;
  logic [BURST_W-1:0] sh_burst;
  logic [GAP_W-1:0]   sh_gap;
  logic [REP_W-1:0]   sh_rep;

  logic burst_end;
  logic run_complete;
  logic gap_load;
  logic gap_expired;

  assign cfg_rdy = (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign gate    = (state == ST_RUN);

  assign burst_end    = (state == ST_RUN) && src_valid && (sh_burst != '0) &&
                        (batch_count == (sh_burst - BURST_W'(1)));
  assign run_complete = (sh_rep != '0) && ((burst_count + REP_W'(1)) == sh_rep);
  assign gap_load     = burst_end && !stop && !run_complete && (sh_gap != '0);

  gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk     (clk),
    .rstn    (rstn),
    .load    (gap_load),
    .enable  (state == ST_GAP),
    .gap     (sh_gap),
    .expired (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_burst <= '0;
      sh_gap   <= '0;
      sh_rep   <= '0;
    end else if (cfg_valid && cfg_rdy) begin
      sh_burst <= cfg_burst_size;
      sh_gap   <= cfg_gap;
      sh_rep   <= cfg_repeats;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      halt        <= 1'b0;
      done        <= 1'b0;
      batch_count <= '0;
      burst_count <= '0;
    end else begin
      halt <= 1'b0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // A same-cycle stop cancels the start request.
          if (start && !stop) begin
            state       <= ST_ARM;
            burst_count <= '0;
          end
        end
        ST_ARM: begin
          if (stop) begin
            state <= ST_IDLE;
            halt  <= 1'b1;
          end else if (dac_rdy) begin
            state       <= ST_RUN;
            batch_count <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            halt  <= 1'b1;
          end else if (burst_end) begin
            halt        <= 1'b1;
            batch_count <= '0;
            burst_count <= burst_count + REP_W'(1);
            if (run_complete) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else if (sh_gap == '0) begin
              state <= ST_ARM;
            end else begin
              state <= ST_GAP;
            end
          end else if (src_valid) begin
            batch_count <= batch_count + BURST_W'(1);
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
            halt  <= 1'b1;
          end else if (gap_expired) begin
            state <= ST_ARM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_burst_scheduler.sv
// tb/tb_dac_burst_scheduler.sv - directed self-checking bench for dac_burst_scheduler
module tb_dac_burst_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_valid;
  logic        cfg_rdy;
  logic [15:0] cfg_burst_size;
  logic [15:0] cfg_gap;
  logic [7:0]  cfg_repeats;
  logic        start;
  logic        stop;
  logic        dac_rdy;
  logic        src_valid;
  logic        gate;
  logic        halt;
  logic        busy;
  logic        done;
  logic [15:0] batch_count;
  logic [7:0]  burst_count;

  int checks = 0;
  int errors = 0;
  int halt_seen;

  always #5 clk = ~clk;

  dac_burst_scheduler dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_valid      (cfg_valid),
    .cfg_rdy        (cfg_rdy),
    .cfg_burst_size (cfg_burst_size),
    .cfg_gap        (cfg_gap),
    .cfg_repeats    (cfg_repeats),
    .start          (start),
    .stop           (stop),
    .dac_rdy        (dac_rdy),
    .src_valid      (src_valid),
    .gate           (gate),
    .halt           (halt),
    .busy           (busy),
    .done           (done),
    .batch_count    (batch_count),
    .burst_count    (burst_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [15:0] b, input logic [15:0] g, input logic [7:0] r);
    cfg_valid      = 1'b1;
    cfg_burst_size = b;
    cfg_gap        = g;
    cfg_repeats    = r;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cfg_valid = 1'b0; cfg_burst_size = '0; cfg_gap = '0; cfg_repeats = '0;
    start = 1'b0; stop = 1'b0; dac_rdy = 1'b0; src_valid = 1'b0;

    tick(); tick();
    chk("rst_gate", gate, 0);
    chk("rst_halt", halt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_rdy", cfg_rdy, 1);
    chk("rst_batch", batch_count, 0);
    chk("rst_burst", burst_count, 0);
    rstn = 1'b1;
    tick();

    // Two bursts of 4 with a 3-cycle gap, finishing after 2 repeats.
    load_cfg(16'd4, 16'd3, 8'd2);
    start = 1'b1; dac_rdy = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("b41_arm_busy", busy, 1);
    chk("b41_arm_gate", gate, 0);
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk($sformatf("b41_gate_c%0d", c), gate, ((c >= 1 && c <= 4) || (c >= 9 && c <= 12)) ? 1 : 0);
      chk($sformatf("b41_halt_c%0d", c), halt, (c == 5 || c == 13) ? 1 : 0);
      chk($sformatf("b41_done_c%0d", c), done, (c == 13) ? 1 : 0);
      if (c == 4) chk("b41_batch_c4", batch_count, 3);
      if (c == 5) chk("b41_burst_c5", burst_count, 1);
      if (c == 8) chk("b41_arm_c8_busy", busy, 1);
    end
    chk("b41_final_burst", burst_count, 2);
    chk("b41_final_busy", busy, 0);
    chk("b41_final_cfg_rdy", cfg_rdy, 1);

    // Continuous mode: 100 batches, no halt until stop.
    src_valid = 1'b0;
    load_cfg(16'd0, 16'd0, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("c42_run_gate", gate, 1);
    chk("c42_run_batch0", batch_count, 0);
    src_valid = 1'b1;
    halt_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (halt) halt_seen++;
    end
    chk("c42_batch100", batch_count, 100);
    chk("c42_no_halt", halt_seen, 0);
    chk("c42_still_run", gate, 1);
    src_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("c42_stop_halt", halt, 1);
    chk("c42_stop_busy", busy, 0);
    chk("c42_stop_done", done, 0);
    tick();
    chk("c42_halt_once", halt, 0);

    // Stop coinciding with the burst-ending batch wins over the burst end.
    load_cfg(16'd3, 16'd0, 8'd0);
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("c43_batch2", batch_count, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("c43_busy", busy, 0);
    chk("c43_halt", halt, 1);
    chk("c43_burst", burst_count, 0);
    chk("c43_done", done, 0);
    tick();
    chk("c43_halt_once", halt, 0);

    // Configuration offered mid-run must be refused.
    src_valid = 1'b0;
    load_cfg(16'd2, 16'd0, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("c44_run_cfg_rdy", cfg_rdy, 0);
    cfg_valid = 1'b1; cfg_burst_size = 16'd5; cfg_gap = 16'd0; cfg_repeats = 8'd1;
    tick();
    cfg_valid = 1'b0; src_valid = 1'b1;
    tick();
    chk("c44_batch1_busy", busy, 1);
    tick();
    chk("c44_old_burst_done", done, 1);
    chk("c44_idle", busy, 0);
    chk("c44_cfg_rdy_back", cfg_rdy, 1);
    load_cfg(16'd1, 16'd0, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("c44_new_run_gate", gate, 1);
    tick();
    chk("c44_new_cfg_done", done, 1);
    chk("c44_new_cfg_idle", busy, 0);

    // ARM waits for dac_rdy.
    src_valid = 1'b0; dac_rdy = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("c45_arm_busy_%0d", i), busy, 1);
      chk($sformatf("c45_arm_gate_%0d", i), gate, 0);
    end
    dac_rdy = 1'b1;
    tick();
    chk("c45_run_gate", gate, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("c45_stop_idle", busy, 0);
    chk("c45_stop_halt", halt, 1);

    // Start and stop together in IDLE, and stop alone in IDLE, do nothing.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("idle_ss_busy", busy, 0);
    chk("idle_ss_halt", halt, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_halt", halt, 0);

    // Reset in GAP aborts silently.
    load_cfg(16'd2, 16'd5, 8'd0);
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("c46_gap_halt", halt, 1);
    chk("c46_gap_gate", gate, 0);
    chk("c46_gap_busy", busy, 1);
    chk("c46_gap_burst", burst_count, 1);
    tick();
    chk("c46_gap_still", busy, 1);
    rstn = 1'b0;
    tick();
    chk("c46_rst_busy", busy, 0);
    chk("c46_rst_gate", gate, 0);
    chk("c46_rst_halt", halt, 0);
    chk("c46_rst_done", done, 0);
    chk("c46_rst_burst", burst_count, 0);
    chk("c46_rst_batch", batch_count, 0);
    rstn = 1'b1; src_valid = 1'b0;
    tick();
    chk("c46_post_halt", halt, 0);
    chk("c46_post_done", done, 0);
    chk("c46_post_cfg_rdy", cfg_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_burst_scheduler.md
DAC_BURST_SCHEDULER -- requirements
Module: dac_burst_scheduler

Interface
REQ-001 Parameter BURST_W, default 16: width of the batches-per-burst count.
REQ-002 Parameter GAP_W, default 16: width of the inter-burst idle-cycle count.
REQ-003 Parameter REP_W, default 8: width of the burst repeat count.
REQ-004 Clocking SHALL be one clock; reset SHALL be synchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rstn  in  1  synchronous active-low reset.
REQ-007 cfg_valid  in  1  new configuration offered.
REQ-008 cfg_rdy  out  1  configuration accepted; high only in IDLE.
REQ-009 cfg_burst_size  in  BURST_W  batches per burst; 0 = continuous.
REQ-010 cfg_gap  in  GAP_W  idle cycles between bursts.
REQ-011 cfg_repeats  in  REP_W  bursts per run; 0 = infinite.
REQ-012 start  in  1  single-cycle run request.
REQ-013 stop  in  1  single-cycle abort request.
REQ-014 dac_rdy  in  1  DAC ready.
REQ-015 src_valid  in  1  DAC interface presented a valid batch.
REQ-016 gate  out  1  batches may pass to the DAC.
REQ-017 halt  out  1  one-cycle halt pulse to the DAC interface.
REQ-018 busy  out  1  state != IDLE.
REQ-019 done  out  1  one-cycle pulse when all repeats complete.
REQ-020 batch_count  out  BURST_W  batches sent in the current burst.
REQ-021 burst_count  out  REP_W  bursts completed in the current run.

Function
REQ-022 States SHALL be IDLE, ARM, RUN and GAP.
REQ-023 Configuration SHALL be latched into shadow registers on cfg_valid && cfg_rdy; shadow registers SHALL NOT change outside IDLE.
REQ-024 From IDLE, start SHALL move to ARM on the next cycle and clear burst_count; start outside IDLE SHALL be ignored.
REQ-025 In ARM, dac_rdy SHALL move to RUN on the next cycle and clear batch_count.
REQ-026 gate SHALL be high exactly while in RUN (combinational from state).
REQ-027 In RUN, each src_valid SHALL increment batch_count, wrapping to 0 at 2^BURST_W.
REQ-028 Burst end is src_valid in RUN with burst_size != 0 and batch_count == burst_size-1; it SHALL:
- pulse halt on the next cycle;
- increment burst_count;
- reset batch_count to 0.
REQ-029 After burst end, the next state SHALL be:
- IDLE with a done pulse if repeats != 0 and burst_count+1 == repeats;
- otherwise ARM if gap == 0;
- otherwise GAP.
REQ-030 GAP SHALL last exactly gap cycles, using a down-counter loaded with gap, then move to ARM.
REQ-031 With burst_size == 0, RUN SHALL continue until stop; no halt pulse and no burst_count increment SHALL occur.
REQ-032 stop in ARM, RUN or GAP SHALL move to IDLE, pulse halt on the next cycle and not pulse done.
REQ-033 stop SHALL take priority over a same-cycle burst end.
REQ-034 stop in IDLE SHALL be ignored.
REQ-035 start and stop in the same IDLE cycle: stop SHALL win; state remains IDLE.
REQ-036 halt and done SHALL be registered, each asserted for exactly one cycle per event.

Reset
REQ-037 While rstn is low at a clk edge, the block SHALL reset to:
- state IDLE;
- gate=0, halt=0, busy=0, done=0, cfg_rdy=1 after release;
- all counters and shadow registers = 0.
REQ-038 Reset mid-run SHALL abort without a halt or done pulse.

Structure
REQ-039 The state enum typedef and the BURST_W, GAP_W and REP_W defaults SHALL reside in mem_layout_pkg.
REQ-040 The GAP countdown SHALL be the sole sub-module, gap_timer (load, enable, expired).

Verification
REQ-041 cfg (burst=4, gap=3, repeats=2), start, dac_rdy=1, src_valid continuous -> two 4-cycle gate windows separated by 3 GAP cycles plus 1 ARM cycle; halt after each burst; done once; burst_count=2.
REQ-042 cfg burst=0, start, 100 src_valid -> batch_count=100, no halt; then stop -> halt pulse, IDLE, no done.
REQ-043 burst=3, stop asserted on the cycle of the 3rd src_valid -> IDLE, one halt, burst_count unchanged, no done.
REQ-044 cfg_valid while in RUN -> cfg_rdy=0, shadow burst size unchanged; after return to IDLE the new config is accepted.
REQ-045 dac_rdy held low 10 cycles after start -> state stays ARM, gate=0; dac_rdy rises -> RUN next cycle.
REQ-046 rstn low during GAP -> next cycle IDLE, all outputs 0, no halt or done pulse.
